// File: rtl/btn_conditioner.sv
// Push-button front end: two-flop synchroniser, then a per-button debounce FSM.
// The FSM produces a clean level, one-cycle press/release pulses and typematic repeat pulses.
// Channel order on every vector is l, r, u, d, c = bits 0..4.
module btn_conditioner #(
    parameter int unsigned NBTN        = 5,
    parameter int unsigned DB_CYCLES   = 400000,
    parameter int unsigned HOLD_CYCLES = 20000000,
    parameter int unsigned RPT_CYCLES  = 4000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] raw,
    output logic [NBTN-1:0] level,
    output logic [NBTN-1:0] down,
    output logic [NBTN-1:0] up,
    output logic [NBTN-1:0] rpt
);

    localparam int unsigned MaxDbHold = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
    localparam int unsigned MaxCycles = (MaxDbHold > RPT_CYCLES) ? MaxDbHold : RPT_CYCLES;
    localparam int unsigned CNTW      = $clog2(MaxCycles + 1);

    localparam logic [CNTW-1:0] DbLast   = CNTW'(DB_CYCLES - 1);
    localparam logic [CNTW-1:0] HoldLast = CNTW'(HOLD_CYCLES - 1);
    localparam logic [CNTW-1:0] RptLast  = CNTW'(RPT_CYCLES - 1);

    typedef enum logic [1:0] {
        StLo,
        StPendHi,
        StHi,
        StPendLo
    } state_e;

    logic [NBTN-1:0] s1_q, s1_d;
    logic [NBTN-1:0] s2_q, s2_d;
    state_e          state_q [NBTN];
    state_e          state_d [NBTN];
    logic [CNTW-1:0] cnt_q   [NBTN];
    logic [CNTW-1:0] cnt_d   [NBTN];
    // first_q marks that the initial hold delay, not the repeat period, is being timed
    logic [NBTN-1:0] first_q, first_d;
    logic [NBTN-1:0] level_q, level_d;
    logic [NBTN-1:0] down_q, down_d;
    logic [NBTN-1:0] up_q, up_d;
    logic [NBTN-1:0] rpt_q, rpt_d;

    // Next-state logic: synchroniser shift plus one debounce/repeat FSM per channel
    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        level_d = level_q;
        down_d  = '0;
        up_d    = '0;
        rpt_d   = '0;
        for (int i = 0; i < NBTN; i++) begin
            unique case (state_q[i])
                StLo: begin
                    if (s2_q[i]) begin
                        state_d[i] = StPendHi;
                        cnt_d[i]   = '0;
                    end
                end
                StPendHi: begin
                    if (!s2_q[i]) begin
                        state_d[i] = StLo;
                    end else if (cnt_q[i] == DbLast) begin
                        state_d[i] = StHi;
                        level_d[i] = 1'b1;
                        down_d[i]  = 1'b1;
                        cnt_d[i]   = '0;
                        first_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNTW'(1);
                    end
                end
                StHi: begin
                    if (!s2_q[i]) begin
                        state_d[i] = StPendLo;
                        cnt_d[i]   = '0;
                    end else if (first_q[i] && cnt_q[i] == HoldLast) begin
                        rpt_d[i]   = 1'b1;
                        cnt_d[i]   = '0;
                        first_d[i] = 1'b0;
                    end else if (!first_q[i] && cnt_q[i] == RptLast) begin
                        rpt_d[i] = 1'b1;
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNTW'(1);
                    end
                end
                StPendLo: begin
                    if (s2_q[i]) begin
                        // Release bounce: re-arm the full hold delay
                        state_d[i] = StHi;
                        cnt_d[i]   = '0;
                        first_d[i] = 1'b1;
                    end else if (cnt_q[i] == DbLast) begin
                        state_d[i] = StLo;
                        level_d[i] = 1'b0;
                        up_d[i]    = 1'b1;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNTW'(1);
                    end
                end
            endcase
        end
    end

    // State and registered outputs; reset drops everything at once, without a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            first_q <= '0;
            level_q <= '0;
            down_q  <= '0;
            up_q    <= '0;
            rpt_q   <= '0;
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= StLo;
                cnt_q[i]   <= '0;
            end
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            first_q <= first_d;
            level_q <= level_d;
            down_q  <= down_d;
            up_q    <= up_d;
            rpt_q   <= rpt_d;
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign level = level_q;
    assign down  = down_q;
    assign up    = up_q;
    assign rpt   = rpt_q;

endmodule
